// File: rtl/ram_bank_pkg.sv
// Shared types and helpers for the scratch RAM bank.
// Holds the clear-FSM state enum and the byte-lane merge used by write and bypass paths.
package ram_bank_pkg;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  // Merge is done at a fixed maximum width so one function
  // serves every BUS_WIDTH up to 256; callers extend and truncate.
  localparam int MAX_W = 256;
  localparam int MAX_S = MAX_W / 8;

  function automatic logic [MAX_W-1:0] byte_merge(
    input logic [MAX_W-1:0] old_w,
    input logic [MAX_W-1:0] new_w,
    input logic [MAX_S-1:0] strb
  );
    logic [MAX_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_S; i++) begin
      if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_addr_decode.sv
// Combinational window decode: in_range when ADDR_BASE <= addr < ADDR_BASE+MEM_SIZE.
// Ports: addr in; in_range, idx (addr - ADDR_BASE truncated) out.
module ram_addr_decode #(
  parameter int BUS_WIDTH = 32,
  parameter int ADDR_BASE = 10,
  parameter int MEM_SIZE  = 32,
  localparam int IDX_WIDTH = $clog2(MEM_SIZE)
) (
  input  logic [BUS_WIDTH-1:0] addr,
  output logic                 in_range,
  output logic [IDX_WIDTH-1:0] idx
);

  // One extra bit so ADDR_BASE+MEM_SIZE never wraps.
  localparam int EW = BUS_WIDTH + 1;
  localparam logic [EW-1:0] LO = EW'(ADDR_BASE);
  localparam logic [EW-1:0] HI = EW'(ADDR_BASE + MEM_SIZE);
  localparam logic [BUS_WIDTH-1:0] BASE = BUS_WIDTH'(ADDR_BASE);

  logic [EW-1:0] a_ext;

  always_comb begin
    a_ext    = {1'b0, addr};
    in_range = (a_ext >= LO) && (a_ext < HI);
    idx      = IDX_WIDTH'(addr - BASE);
  end

endmodule

// File: rtl/ram_memory_bank.sv
// Word-addressed scratch RAM with byte strobes, registered read and range checks.
// Ports: clk, reset (async high), busy, write_en/strb/addr_write/data_write, write_err,
// read_en/addr_read, data_read, read_valid, read_err. Option: RAM_BANK_BYPASS_EN (write-first).
module ram_memory_bank
  import ram_bank_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int ADDR_BASE = 10,
  parameter int MEM_SIZE  = 32,
  localparam int IDX_WIDTH  = $clog2(MEM_SIZE),
  localparam int STRB_WIDTH = BUS_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  busy,
  input  logic                  write_en,
  input  logic [STRB_WIDTH-1:0] write_strb,
  input  logic [BUS_WIDTH-1:0]  addr_write,
  input  logic [BUS_WIDTH-1:0]  data_write,
  output logic                  write_err,
  input  logic                  read_en,
  input  logic [BUS_WIDTH-1:0]  addr_read,
  output logic [BUS_WIDTH-1:0]  data_read,
  output logic                  read_valid,
  output logic                  read_err
);

  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(MEM_SIZE - 1);

  state_t               state;
  logic [IDX_WIDTH-1:0] clr_cnt;
  logic [BUS_WIDTH-1:0] mem [MEM_SIZE];

  logic                 wr_in_range;
  logic [IDX_WIDTH-1:0] wr_idx;
  logic                 rd_in_range;
  logic [IDX_WIDTH-1:0] rd_idx;
  logic [BUS_WIDTH-1:0] wr_merged;
  logic [BUS_WIDTH-1:0] rd_word;

  ram_addr_decode #(
    .BUS_WIDTH(BUS_WIDTH),
    .ADDR_BASE(ADDR_BASE),
    .MEM_SIZE (MEM_SIZE)
  ) u_wr_dec (
    .addr    (addr_write),
    .in_range(wr_in_range),
    .idx     (wr_idx)
  );

  ram_addr_decode #(
    .BUS_WIDTH(BUS_WIDTH),
    .ADDR_BASE(ADDR_BASE),
    .MEM_SIZE (MEM_SIZE)
  ) u_rd_dec (
    .addr    (addr_read),
    .in_range(rd_in_range),
    .idx     (rd_idx)
  );

  always_comb begin
    wr_merged = BUS_WIDTH'(byte_merge(
      MAX_W'(mem[wr_idx]),
      MAX_W'(data_write),
      MAX_S'(write_strb)));
`ifdef RAM_BANK_BYPASS_EN
    // Write-first: a same-index write is forwarded into the read.
    if (write_en && wr_in_range && (wr_idx == rd_idx))
      rd_word = wr_merged;
    else
      rd_word = mem[rd_idx];
`else
    rd_word = mem[rd_idx];
`endif
  end

  // Array has no reset; the INIT pass zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (state == ST_INIT)
      mem[clr_cnt] <= '0;
    else if (write_en && wr_in_range)
      mem[wr_idx] <= wr_merged;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_INIT;
      clr_cnt    <= '0;
      busy       <= 1'b1;
      data_read  <= '0;
      read_valid <= 1'b0;
      read_err   <= 1'b0;
      write_err  <= 1'b0;
    end else begin
      read_valid <= 1'b0;
      read_err   <= 1'b0;
      write_err  <= 1'b0;
      unique case (state)
        ST_INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST) begin
            state <= ST_READY;
            busy  <= 1'b0;
          end
        end
        ST_READY: begin
          write_err <= write_en && !wr_in_range;
          if (read_en) begin
            read_valid <= 1'b1;
            read_err   <= !rd_in_range;
            data_read  <= rd_in_range ? rd_word : '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_memory_bank.sv
// Scoreboard bench for ram_memory_bank: stimulus pushes expectations,
// a negedge monitor pops and compares on read_valid / write_err.
module tb_ram_memory_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic        write_en;
  logic [3:0]  write_strb;
  logic [31:0] addr_write;
  logic [31:0] data_write;
  logic        write_err;
  logic        read_en;
  logic [31:0] addr_read;
  logic [31:0] data_read;
  logic        read_valid;
  logic        read_err;

  ram_memory_bank dut (
    .clk       (clk),
    .reset     (reset),
    .busy      (busy),
    .write_en  (write_en),
    .write_strb(write_strb),
    .addr_write(addr_write),
    .data_write(data_write),
    .write_err (write_err),
    .read_en   (read_en),
    .addr_read (addr_read),
    .data_read (data_read),
    .read_valid(read_valid),
    .read_err  (read_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } rexp_t;

  rexp_t       rq[$];
  int          wq[$];
  rexp_t       mr;
  int          mw;
  int          cyc_cnt = 0;
  int          total = 0;
  int          passed = 0;
  logic [31:0] last_exp = '0;
  logic [31:0] mdl [32];

  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (reset) begin
      last_exp = '0;
    end else begin
      if (read_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_read_valid", 32'd1, 32'd0);
        end else begin
          mr = rq.pop_front();
          chk("read_data", data_read, mr.d);
          chk("read_err", {31'd0, read_err}, {31'd0, mr.e});
          chk("read_latency", cyc_cnt, mr.c);
          last_exp = mr.d;
        end
      end else begin
        chk("idle_hold", data_read, last_exp);
        chk("idle_err", {31'd0, read_err}, 32'd0);
      end
      if (write_err) begin
        if (wq.size() == 0) begin
          chk("unexpected_write_err", 32'd1, 32'd0);
        end else begin
          mw = wq.pop_front();
          chk("write_err_cycle", cyc_cnt, mw);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  task automatic set_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit err);
    write_en   = 1'b1;
    addr_write = a;
    data_write = d;
    write_strb = s;
    if (err) wq.push_back(cyc_cnt + 1);
  endtask

  task automatic set_rd(input logic [31:0] a, input logic [31:0] d, input bit err);
    rexp_t r;
    read_en   = 1'b1;
    addr_read = a;
    r.d = d;
    r.e = err;
    r.c = cyc_cnt + 1;
    rq.push_back(r);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_data"}, data_read, 32'd0);
    chk({tag, "_valid"}, {31'd0, read_valid}, 32'd0);
    chk({tag, "_rerr"}, {31'd0, read_err}, 32'd0);
    chk({tag, "_werr"}, {31'd0, write_err}, 32'd0);
  endtask

  task automatic wait_init(input string tag, input bit poke);
    int n;
    n = 0;
    if (poke) begin
      write_en   = 1'b1;
      addr_write = 32'd11;
      data_write = 32'hDEADBEEF;
      write_strb = 4'hF;
      read_en    = 1'b1;
      addr_read  = 32'd11;
    end
    while (busy && n < 100) begin
      tick();
      n++;
    end
    idle();
    chk({tag, "_busy_cycles"}, n, 32'd32);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      set_rd(32'(10 + i), mdl[i], 1'b0);
      tick();
    end
    idle();
    repeat (2) tick();
    chk({tag, "_drain"}, rq.size(), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    write_en   = 1'b0;
    read_en    = 1'b0;
    write_strb = '0;
    addr_write = '0;
    data_write = '0;
    addr_read  = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("rst0");
    reset = 1'b0;

    // Clear pass; writes and reads during busy must be ignored
    wait_init("init0", 1'b1);

    set_rd(32'd11, 32'h0, 1'b0);
    tick();
    idle();

    // Byte strobes
    set_wr(32'd11, 32'h11223344, 4'hF, 1'b0);
    tick();
    set_wr(32'd11, 32'hAABBCCDD, 4'b0101, 1'b0);
    tick();
    idle();
    set_rd(32'd11, 32'h11BB33DD, 1'b0);
    tick();
    idle();
    mdl[1] = 32'h11BB33DD;

    // Strobe zero is a no-op without error
    set_wr(32'd11, 32'hFFFFFFFF, 4'h0, 1'b0);
    tick();
    idle();

    // Out of range both ends
    set_wr(32'd42, 32'hCAFEF00D, 4'hF, 1'b1);
    tick();
    idle();
    set_wr(32'd9, 32'hCAFEF00D, 4'hF, 1'b1);
    tick();
    idle();
    set_rd(32'd9, 32'h0, 1'b1);
    tick();
    set_rd(32'd42, 32'h0, 1'b1);
    tick();
    set_rd(32'hFFFFFFFF, 32'h0, 1'b1);
    tick();
    idle();
    sweep("oor");

    // Collision at last word
    set_wr(32'd41, 32'h5, 4'hF, 1'b0);
`ifdef RAM_BANK_BYPASS_EN
    set_rd(32'd41, 32'h5, 1'b0);
`else
    set_rd(32'd41, 32'h0, 1'b0);
`endif
    tick();
    idle();
    set_rd(32'd41, 32'h5, 1'b0);
    tick();
    idle();
    mdl[31] = 32'h5;

    // Back-to-back reads, then hold
    set_rd(32'd10, 32'h0, 1'b0);
    tick();
    set_rd(32'd11, 32'h11BB33DD, 1'b0);
    tick();
    set_rd(32'd41, 32'h5, 1'b0);
    tick();
    idle();
    repeat (3) tick();

    // Reset mid write burst
    set_wr(32'd12, 32'h01010101, 4'hF, 1'b0);
    tick();
    set_wr(32'd13, 32'h02020202, 4'hF, 1'b0);
    tick();
    set_wr(32'd14, 32'h03030303, 4'hF, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outs("rst1");
    idle();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    wait_init("init1", 1'b0);
    sweep("clr");

    repeat (3) tick();
    chk("rq_empty", rq.size(), 32'd0);
    chk("wq_empty", wq.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
